// File: rtl/data_mem_arb_if.sv
// Requester-side bus of the data memory arbiter: one write port and one read port.
// Carries wr_be only when DATA_MEM_BYTE_MASK_EN is defined.
interface data_mem_arb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                    wr_req;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
`ifdef DATA_MEM_BYTE_MASK_EN
    logic [DATA_WIDTH/8-1:0] wr_be;
`endif
    logic                    wr_ack;
    logic                    rd_req;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic                    rd_ack;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    rd_data_valid;
    logic                    addr_err;

    modport master (
`ifdef DATA_MEM_BYTE_MASK_EN
        output wr_be,
`endif
        output wr_req, wr_addr, wr_data, rd_req, rd_addr,
        input  wr_ack, rd_ack, rd_data, rd_data_valid, addr_err
    );

    modport slave (
`ifdef DATA_MEM_BYTE_MASK_EN
        input  wr_be,
`endif
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
        output wr_ack, rd_ack, rd_data, rd_data_valid, addr_err
    );
endinterface

// File: rtl/data_mem_arb.sv
// Single-port data memory shared by a write and a read requester, round-robin arbitrated.
// Define DATA_MEM_BYTE_MASK_EN to enable per-byte write enables (wr_be).
module data_mem_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int MEM_DEPTH  = 1024,
    parameter int RD_LATENCY = 2
) (
    input logic           clk,
    input logic           reset,
    data_mem_arb_if.slave bus
);
    localparam int                  STAGES = RD_LATENCY - 1;
    localparam int                  IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH  = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    typedef enum logic {GNT_READ, GNT_WRITE} grant_e;

    grant_e                          last_grant;
    logic                            wr_fire, rd_fire;
    logic                            wr_in_range, rd_in_range;
    logic [IDX_W-1:0]                wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0]           rd_word;
    logic [DATA_WIDTH-1:0]           mem [MEM_DEPTH];
    logic [STAGES:0]                 vld_pipe;
    logic [STAGES:0][DATA_WIDTH-1:0] data_pipe;
    logic                            addr_err_q;

    assign wr_in_range = {1'b0, bus.wr_addr} < DEPTH;
    assign rd_in_range = {1'b0, bus.rd_addr} < DEPTH;
    assign wr_idx      = bus.wr_addr[IDX_W-1:0];
    assign rd_idx      = bus.rd_addr[IDX_W-1:0];

    // Contention goes to whichever port did not win the last grant.
    always_comb begin
        wr_fire = 1'b0;
        rd_fire = 1'b0;
        if (!reset) begin
            if (bus.wr_req && bus.rd_req) begin
                wr_fire = (last_grant == GNT_READ);
                rd_fire = (last_grant == GNT_WRITE);
            end else begin
                wr_fire = bus.wr_req;
                rd_fire = bus.rd_req;
            end
        end
    end

    assign bus.wr_ack        = wr_fire;
    assign bus.rd_ack        = rd_fire;
    assign bus.rd_data       = data_pipe[STAGES];
    assign bus.rd_data_valid = vld_pipe[STAGES];
    assign bus.addr_err      = addr_err_q;

    // Memory contents survive reset; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (wr_fire && wr_in_range) begin
`ifdef DATA_MEM_BYTE_MASK_EN
            for (int b = 0; b < DATA_WIDTH / 8; b++)
                if (bus.wr_be[b])
                    mem[wr_idx][8*b +: 8] <= bus.wr_data[8*b +: 8];
`else
            mem[wr_idx] <= bus.wr_data;
`endif
        end
    end

    assign rd_word = rd_in_range ? mem[rd_idx] : '0;

    // Read word is captured at the grant edge, so later writes cannot disturb it.
    // Each data stage only loads behind a valid, which keeps rd_data held between pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe   <= '0;
            data_pipe  <= '0;
            addr_err_q <= 1'b0;
            last_grant <= GNT_READ;
        end else begin
            vld_pipe[0] <= rd_fire;
            if (rd_fire)
                data_pipe[0] <= rd_word;
            for (int k = 1; k <= STAGES; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                if (vld_pipe[k-1])
                    data_pipe[k] <= data_pipe[k-1];
            end
            addr_err_q <= (wr_fire && !wr_in_range) || (rd_fire && !rd_in_range);
            if (wr_fire)
                last_grant <= GNT_WRITE;
            else if (rd_fire)
                last_grant <= GNT_READ;
        end
    end
endmodule

// File: tb/tb_data_mem_arb.sv
// Directed plus random bench for data_mem_arb (MEM_DEPTH=512, RD_LATENCY=2) with a
// transaction-level reference model: word array, expected-read queue, turn flag.
module tb_data_mem_arb;
    localparam int DW = 32, AW = 10, DEPTH = 512, LAT = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_mem_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    data_mem_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .RD_LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          due;
        logic [31:0] data;
        bit          known;
    } rd_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [31:0] mm [DEPTH];
    bit          known [DEPTH];
    rd_t         rq [$];
    logic [31:0] exp_data = '0;
    bit          data_known = 1'b1;
    bit          exp_err = 1'b0;
    bit          write_turn = 1'b1;
    logic [3:0]  be_drv = 4'hF;
    bit          obs_wack, obs_rack;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    // One clock of traffic: inputs set just after a rising edge, checked at the falling edge.
    task automatic do_cycle(input bit w, input logic [9:0] wa, input logic [31:0] wd,
                            input bit r, input logic [9:0] ra);
        bit ew, er, ev;
        bus.wr_req  = w;
        bus.wr_addr = wa;
        bus.wr_data = wd;
        bus.rd_req  = r;
        bus.rd_addr = ra;
`ifdef DATA_MEM_BYTE_MASK_EN
        bus.wr_be   = be_drv;
`endif
        @(negedge clk);
        if (w && r) begin
            ew = write_turn;
            er = !write_turn;
        end else begin
            ew = w;
            er = r;
        end
        obs_wack = bus.wr_ack;
        obs_rack = bus.rd_ack;
        chk("wr_ack", {31'b0, bus.wr_ack}, {31'b0, ew});
        chk("rd_ack", {31'b0, bus.rd_ack}, {31'b0, er});
        ev = (rq.size() > 0) && (rq[0].due == cyc);
        if (ev) begin
            exp_data   = rq[0].data;
            data_known = rq[0].known;
            void'(rq.pop_front());
        end
        chk("rd_data_valid", {31'b0, bus.rd_data_valid}, {31'b0, ev});
        if (data_known) chk("rd_data", bus.rd_data, exp_data);
        chk("addr_err", {31'b0, bus.addr_err}, {31'b0, exp_err});
        @(posedge clk);
        exp_err = (ew && wa >= DEPTH) || (er && ra >= DEPTH);
        if (ew && wa < DEPTH) begin
            for (int b = 0; b < 4; b++)
                if (be_drv[b]) mm[wa[8:0]][8*b +: 8] = wd[8*b +: 8];
            known[wa[8:0]] = known[wa[8:0]] || (be_drv == 4'hF);
        end
        if (er) rq.push_back('{cyc + LAT, (ra < DEPTH) ? mm[ra[8:0]] : 32'h0,
                               (ra >= DEPTH) || known[ra[8:0]]});
        if (ew) write_turn = 1'b0;
        else if (er) write_turn = 1'b1;
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, '0, '0, 1'b0, '0);
    endtask

    // Reset raised mid-cycle with both requests high; in-flight reads must vanish.
    task automatic mid_reset();
        bus.wr_req = 1'b1;
        bus.rd_req = 1'b1;
        reset      = 1'b1;
        #2;
        chk("rst_wr_ack", {31'b0, bus.wr_ack}, 32'h0);
        chk("rst_rd_ack", {31'b0, bus.rd_ack}, 32'h0);
        chk("rst_rd_valid", {31'b0, bus.rd_data_valid}, 32'h0);
        chk("rst_rd_data", bus.rd_data, 32'h0);
        chk("rst_addr_err", {31'b0, bus.addr_err}, 32'h0);
        @(posedge clk);
        cyc++;
        #1;
        chk("rst_no_late_valid", {31'b0, bus.rd_data_valid}, 32'h0);
        reset      = 1'b0;
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        rq.delete();
        exp_data   = '0;
        data_known = 1'b1;
        exp_err    = 1'b0;
        write_turn = 1'b1;
    endtask

    function automatic logic [9:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 10'h200 + 10'($urandom_range(0, 15));
        return 10'($urandom_range(0, 15));
    endfunction

    initial begin
        logic [31:0] d;
        reset       = 1'b1;
        bus.wr_req  = 1'b0;
        bus.rd_req  = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_addr = '0;
`ifdef DATA_MEM_BYTE_MASK_EN
        bus.wr_be   = 4'hF;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rd_valid", {31'b0, bus.rd_data_valid}, 32'h0);
        chk("reset_rd_data", bus.rd_data, 32'h0);
        chk("reset_addr_err", {31'b0, bus.addr_err}, 32'h0);
        reset = 1'b0;

        // Both requesters held high: grants alternate starting with write.
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b1, 10'h020, 32'hC0DE_0000, 1'b1, 10'h021);
            chk("rr_pattern_w", {31'b0, obs_wack}, {31'b0, (i % 2) == 0});
            chk("rr_pattern_r", {31'b0, obs_rack}, {31'b0, (i % 2) == 1});
        end
        idle(3);

        do_cycle(1'b1, 10'h005, 32'hDEAD_BEEF, 1'b0, '0);
        do_cycle(1'b0, '0, '0, 1'b1, 10'h005);
        idle(1);
        chk("deadbeef_data", bus.rd_data, 32'hDEAD_BEEF);
        idle(2);

        for (int a = 1; a <= 4; a++) do_cycle(1'b1, 10'(a), 32'h1000_0000 + 32'(a), 1'b0, '0);
        for (int a = 1; a <= 4; a++) do_cycle(1'b0, '0, '0, 1'b1, 10'(a));
        idle(3);

        // Out-of-range write must not alias onto word 0.
        do_cycle(1'b1, 10'h000, 32'h0BAD_F00D, 1'b0, '0);
        do_cycle(1'b1, 10'h200, 32'h1234_5678, 1'b0, '0);
        chk("oor_wr_err_pulse", {31'b0, bus.addr_err}, 32'h1);
        do_cycle(1'b0, '0, '0, 1'b1, 10'h200);
        do_cycle(1'b0, '0, '0, 1'b1, 10'h000);
        idle(3);
        chk("oor_alias_word0", bus.rd_data, 32'h0BAD_F00D);

`ifdef DATA_MEM_BYTE_MASK_EN
        do_cycle(1'b1, 10'h007, 32'h1122_3344, 1'b0, '0);
        be_drv = 4'b0101;
        do_cycle(1'b1, 10'h007, 32'hAABB_CCDD, 1'b0, '0);
        be_drv = 4'hF;
        do_cycle(1'b0, '0, '0, 1'b1, 10'h007);
        idle(3);
        chk("byte_mask_merge", bus.rd_data, 32'h11BB_33DD);
`endif

        for (int a = 0; a < 16; a++) do_cycle(1'b1, 10'(a), $urandom, 1'b0, '0);
        for (int i = 0; i < 300; i++) begin
            d = $urandom;
            do_cycle(1'($urandom_range(0, 1)), rand_addr(), d, 1'($urandom_range(0, 1)), rand_addr());
        end
        idle(3);

        do_cycle(1'b0, '0, '0, 1'b1, 10'h003);
        mid_reset();
        idle(4);
        do_cycle(1'b1, 10'h009, 32'h5555_AAAA, 1'b1, 10'h003);
        chk("post_reset_write_first", {31'b0, obs_wack}, 32'h1);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/data_mem_arb.md
DATA_MEM_ARB -- requirements
Module: data_mem_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, address width.
REQ-003 SHALL have parameter MEM_DEPTH, default 1024, word count (1..2^ADDR_WIDTH).
REQ-004 SHALL have parameter RD_LATENCY, default 2, grant-to-data cycles (1..4).
REQ-005 SHALL have port clk, input, 1, sole clock (rising edge).
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port wr_req, input, 1, write request (active-high).
REQ-008 SHALL have port wr_addr, input, ADDR_WIDTH, write address.
REQ-009 SHALL have port wr_data, input, DATA_WIDTH, write data.
REQ-010 SHALL have port wr_ack, output, 1, write granted this cycle.
REQ-011 SHALL have port rd_req, input, 1, read request (active-high).
REQ-012 SHALL have port rd_addr, input, ADDR_WIDTH, read address.
REQ-013 SHALL have port rd_ack, output, 1, read granted this cycle.
REQ-014 SHALL have port rd_data, output, DATA_WIDTH, read data.
REQ-015 SHALL have port rd_data_valid, output, 1, one-cycle pulse qualifying rd_data.
REQ-016 SHALL have port addr_err, output, 1, one-cycle pulse for an out-of-range granted access.

Function
REQ-017 SHALL transfer a request at the rising edge where req and ack are both high; requester holds req/addr/data stable until then.
REQ-018 SHALL grant at most one port per cycle; wr_ack/rd_ack combinational from req and arbiter state.
REQ-019 SHALL grant a sole requester immediately (zero-wait).
REQ-020 SHALL, with both requesting, grant the port not granted most recently (round-robin via registered last_grant; reset value = READ, so write wins first contention).
REQ-021 SHALL update last_grant only on an actual grant.
REQ-022 SHALL write mem[wr_addr] on the granted edge; a read granted the next cycle to that address returns the new data.
REQ-023 SHALL present rd_data with rd_data_valid high exactly RD_LATENCY cycles after the rd_ack edge, through a RD_LATENCY-stage valid/data pipeline, sustaining one read per cycle.
REQ-024 SHALL hold rd_data between valid pulses.
REQ-025 SHALL, for granted address >= MEM_DEPTH, pulse addr_err the following cycle; write discarded; read returns 0 with rd_data_valid at normal latency.
REQ-026 SHALL keep in-flight reads unaffected by later writes (data captured at grant).

Reset
REQ-027 SHALL, on reset assertion, asynchronously clear rd_data to 0, rd_data_valid, addr_err, all pipeline valid bits to 0 and last_grant to READ.
REQ-028 SHALL deassert wr_ack/rd_ack while reset is high.
REQ-029 SHALL discard reads in flight when reset asserts mid-operation (no late rd_data_valid).
REQ-030 SHALL NOT clear memory contents on reset; contents undefined until written.

Configuration
REQ-031 SHALL, with DATA_MEM_BYTE_MASK_EN defined, add input wr_be (DATA_WIDTH/8 bits) and write only bytes whose wr_be bit is 1; DATA_WIDTH SHALL be a multiple of 8.
REQ-032 SHALL, without DATA_MEM_BYTE_MASK_EN, omit wr_be and write full words.

Verification
REQ-033 SHALL cover: write 0xDEADBEEF to 0x005, then read 0x005 -> rd_ack same cycle, rd_data_valid and rd_data=0xDEADBEEF 2 cycles later.
REQ-034 SHALL cover: wr_req and rd_req held high 4 cycles after reset -> grants W,R,W,R.
REQ-035 SHALL cover: back-to-back reads 0x001..0x004 -> 4 consecutive rd_data_valid pulses in order.
REQ-036 SHALL cover: MEM_DEPTH=512, write to 0x200 -> addr_err pulse, mem unchanged; read 0x200 -> rd_data=0.
REQ-037 SHALL cover: reset asserted 1 cycle after read grant -> no rd_data_valid, rd_data=0 immediately.
REQ-038 SHALL cover: with DATA_MEM_BYTE_MASK_EN, 0x11223344 then 0xAABBCCDD with wr_be=0b0101 -> read 0x11BB33DD.
